wb_ram_arbiter: RTL

WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

---
 rtl/wb_ram_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone classic front end for a single-port-pair synchronous RAM.
// Round-robin arbitration; one transaction in flight, latched at grant and run to completion.
module wb_ram_arbiter #(
    parameter int depth = 256,
    localparam int AW = $clog2(depth)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [31:0]   m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    input  logic [31:0]   m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic [3:0]    ram_we,
    output logic [31:0]   ram_din,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    input  logic [31:0]   ram_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, ACK} state_t;

    state_t        state, state_nxt;
    logic          req0, req1, win;
    logic          ptr, gnt;
    logic [AW-1:0] adr_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic [31:0]   rdata;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    // On contention the pointer decides; otherwise whoever asks wins.
    assign win  = (req0 & req1) ? ptr : req1;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ptr   <= 1'b0;
            gnt   <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
            we_q  <= 1'b0;
        end else if (state == IDLE && (req0 | req1)) begin
            gnt   <= win;
            ptr   <= ~win;
            adr_q <= win ? m1_adr_i[AW+1:2] : m0_adr_i[AW+1:2];
            dat_q <= win ? m1_dat_i : m0_dat_i;
            sel_q <= win ? m1_sel_i : m0_sel_i;
            we_q  <= win ? m1_we_i  : m0_we_i;
        end
    end

    // RAM output is registered, so it is valid during RDWAIT and captured here.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            rdata <= '0;
        else if (state == RDWAIT)
            rdata <= ram_dout;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 | req1) state_nxt = ACCESS;
            ACCESS:  state_nxt = we_q ? ACK : RDWAIT;
            RDWAIT:  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ram_we   = (state == ACCESS && we_q) ? sel_q : 4'b0000;
        m0_ack_o = (state == ACK) && !gnt && req0;
        m1_ack_o = (state == ACK) &&  gnt && req1;
    end

    assign ram_waddr = adr_q;
    assign ram_raddr = adr_q;
    assign ram_din   = dat_q;
    assign m0_dat_o  = rdata;
    assign m1_dat_o  = rdata;

    logic unused;
    assign unused = ^{m0_adr_i[31:AW+2], m0_adr_i[1:0], m1_adr_i[31:AW+2], m1_adr_i[1:0]};

endmodule
